// File: rtl/if_map_buf_pp_if.sv
// rtl/if_map_buf_pp_if.sv - fill/MAC-side bus of the ping-pong feature-map buffer
interface if_map_buf_pp_if #(
  parameter int DATA_W    = 16,
  parameter int NUM_REGS  = 64,
  parameter int NUM_PORTS = 8,
  parameter int SEL_W     = $clog2(NUM_PORTS)
);
  logic [NUM_PORTS*DATA_W-1:0] rd_data;
  logic [NUM_REGS-1:0]         reg_load;
  logic [NUM_REGS*SEL_W-1:0]   mux_sel;
  logic [NUM_REGS-1:0]         local_clr;
  logic                        shift_en;
  logic                        fill_commit;
  logic                        fill_ready;
  logic                        mac_release;
  logic                        mac_valid;
  logic [NUM_REGS*DATA_W-1:0]  mac_in;
  logic [1:0]                  full_cnt;
  logic                        err;
  logic                        err_clr;

  modport master (
    output rd_data, reg_load, mux_sel, local_clr, shift_en, fill_commit, mac_release, err_clr,
    input  fill_ready, mac_valid, mac_in, full_cnt, err
  );

  modport slave (
    input  rd_data, reg_load, mux_sel, local_clr, shift_en, fill_commit, mac_release, err_clr,
    output fill_ready, mac_valid, mac_in, full_cnt, err
  );
endinterface

// File: rtl/if_map_buf_pp.sv
// rtl/if_map_buf_pp.sv - double-buffered input-feature-map registers feeding the MAC operand bus
module if_map_buf_pp #(
  parameter int DATA_W     = 16,
  parameter int NUM_REGS   = 64,
  parameter int NUM_PORTS  = 8,
  parameter int SEL_W      = $clog2(NUM_PORTS),
  parameter int SHIFT_STEP = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  if_map_buf_pp_if.slave  bus
);
  typedef logic [DATA_W-1:0] word_t;

  word_t       bank_q    [2][NUM_REGS];
  word_t       fill_d    [NUM_REGS];
  word_t       shift_src [NUM_REGS];
  word_t       port_data [NUM_PORTS];
  logic        wr_bank_q;
  logic        rd_bank_q;
  logic [1:0]  full_q;
  logic        err_q;

  logic        fill_ready;
  logic        mac_valid;
  logic        fill_wr_req;
  logic        err_set;
  logic [SEL_W-1:0] sel;

  assign fill_ready = ~full_q[wr_bank_q];
  assign mac_valid  = full_q[rd_bank_q];

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      port_data[p] = bus.rd_data[p*DATA_W +: DATA_W];
    end
  end

  // Shift source is always the pre-edge fill bank, so load and shift never chain.
  always_comb begin
    shift_src = '{default: '0};
    for (int i = 0; i < NUM_REGS - SHIFT_STEP; i++) begin
      shift_src[i] = bank_q[wr_bank_q][i + SHIFT_STEP];
    end
  end

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      sel = bus.mux_sel[i*SEL_W +: SEL_W];
      if (bus.local_clr[i]) begin
        fill_d[i] = '0;
      end else if (bus.reg_load[i]) begin
        fill_d[i] = (32'(sel) < NUM_PORTS) ? port_data[sel] : '0;
      end else if (bus.shift_en) begin
        fill_d[i] = shift_src[i];
      end else begin
        fill_d[i] = bank_q[wr_bank_q][i];
      end
    end
  end

  assign fill_wr_req = bus.fill_commit | bus.shift_en | (|bus.reg_load) | (|bus.local_clr);
  assign err_set     = (fill_wr_req & ~fill_ready) | (bus.mac_release & ~mac_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q    <= '{default: '{default: '0}};
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q    <= 2'b00;
      err_q     <= 1'b0;
    end else begin
      if (fill_ready) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          bank_q[wr_bank_q][i] <= fill_d[i];
        end
      end
      // Commit and release always address different banks, so both may act at once.
      if (bus.fill_commit && fill_ready) begin
        full_q[wr_bank_q] <= 1'b1;
        wr_bank_q         <= ~wr_bank_q;
      end
      if (bus.mac_release && mac_valid) begin
        full_q[rd_bank_q] <= 1'b0;
        rd_bank_q         <= ~rd_bank_q;
      end
      if (err_set) begin
        err_q <= 1'b1;
      end else if (bus.err_clr) begin
        err_q <= 1'b0;
      end
    end
  end

  always_comb begin
    bus.mac_in = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      bus.mac_in[i*DATA_W +: DATA_W] = mac_valid ? bank_q[rd_bank_q][i] : '0;
    end
  end

  assign bus.fill_ready = fill_ready;
  assign bus.mac_valid  = mac_valid;
  assign bus.full_cnt   = {1'b0, full_q[0]} + {1'b0, full_q[1]};
  assign bus.err        = err_q;
endmodule

// File: tb/tb_if_map_buf_pp.sv
// tb/tb_if_map_buf_pp.sv - bench for if_map_buf_pp: window-queue model plus directed literal checks
module tb_if_map_buf_pp;
  localparam int DW = 16;
  localparam int NR = 64;
  localparam int NP = 8;
  localparam int SW = 3;
  localparam int VW = NR*DW;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  if_map_buf_pp_if bus ();

  if_map_buf_pp dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: committed windows form a FIFO (front = what the MACs see), the fill
  // window is being edited, and the idle window is the one last handed back.
  logic [VW-1:0] q_m [$];
  logic [VW-1:0] fill_m, idle_m, pre_m, popped_m;
  logic          err_m, fr_m, mv_m, wr_req_m;
  int            sel_m;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_m.delete();
      fill_m = '0;
      idle_m = '0;
      err_m  = 1'b0;
    end else begin
      fr_m     = (q_m.size() < 2);
      mv_m     = (q_m.size() > 0);
      wr_req_m = bus.fill_commit | bus.shift_en | (|bus.reg_load) | (|bus.local_clr);
      pre_m    = fill_m;
      if (fr_m) begin
        for (int i = 0; i < NR; i++) begin
          sel_m = int'(bus.mux_sel[i*SW +: SW]);
          if (bus.local_clr[i])
            fill_m[i*DW +: DW] = '0;
          else if (bus.reg_load[i])
            fill_m[i*DW +: DW] = (sel_m < NP) ? DW'(bus.rd_data >> (DW*sel_m)) : '0;
          else if (bus.shift_en)
            fill_m[i*DW +: DW] = (i + 8 < NR) ? pre_m[(i+8)*DW +: DW] : '0;
        end
      end
      if ((wr_req_m && !fr_m) || (bus.mac_release && !mv_m))
        err_m = 1'b1;
      else if (bus.err_clr)
        err_m = 1'b0;
      if (bus.mac_release && mv_m) begin
        popped_m = q_m.pop_front();
        if (q_m.size() == 1) fill_m = popped_m;
        else idle_m = popped_m;
      end
      if (bus.fill_commit && fr_m) begin
        q_m.push_back(fill_m);
        fill_m = idle_m;
      end
    end
  end

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_lanes(input string name, input logic [VW-1:0] exp);
    total++;
    if (bus.mac_in !== exp) begin
      bad++;
      for (int i = 0; i < NR; i++) begin
        if (bus.mac_in[i*DW +: DW] !== exp[i*DW +: DW]) begin
          $display("FAIL %s: lane %0d got %0h expected %0h at %0t", name, i,
                   bus.mac_in[i*DW +: DW], exp[i*DW +: DW], $time);
          break;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    cmp("m_fill_ready", 64'(bus.fill_ready), 64'(q_m.size() < 2));
    cmp("m_mac_valid", 64'(bus.mac_valid), 64'(q_m.size() > 0));
    cmp("m_full_cnt", 64'(bus.full_cnt), 64'(q_m.size()));
    cmp("m_err", 64'(bus.err), 64'(err_m));
    cmp_lanes("m_mac_in", (q_m.size() > 0) ? q_m[0] : '0);
  end

  function automatic logic [VW-1:0] pat_mod(input int base);
    logic [VW-1:0] v;
    for (int i = 0; i < NR; i++) v[i*DW +: DW] = DW'(base + (i % 8));
    return v;
  endfunction

  function automatic logic [VW-1:0] pat_shifted();
    logic [VW-1:0] v;
    for (int i = 0; i < NR; i++) v[i*DW +: DW] = (i < 56) ? DW'(i + 8) : '0;
    return v;
  endfunction

  task automatic clear_in();
    bus.rd_data     = '0;
    bus.reg_load    = '0;
    bus.local_clr   = '0;
    bus.shift_en    = 1'b0;
    bus.fill_commit = 1'b0;
    bus.mac_release = 1'b0;
    bus.err_clr     = 1'b0;
    for (int i = 0; i < NR; i++) bus.mux_sel[i*SW +: SW] = SW'(i % 8);
  endtask

  task automatic set_ports(input int base);
    for (int p = 0; p < NP; p++) bus.rd_data[p*DW +: DW] = DW'(base + p);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clear_in();
  endtask

  task automatic load_identity();
    for (int k = 0; k < 8; k++) begin
      set_ports(8*k);
      bus.reg_load = 64'hFF << (8*k);
      tick();
    end
  endtask

  logic [VW-1:0] exp_v;

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    clear_in();
    #12;
    rst_n = 1'b1;

    cmp("rst_fill_ready", 64'(bus.fill_ready), 64'd1);
    cmp("rst_mac_valid", 64'(bus.mac_valid), 64'd0);
    cmp("rst_full_cnt", 64'(bus.full_cnt), 64'd0);
    cmp("rst_err", 64'(bus.err), 64'd0);
    cmp_lanes("rst_mac_in", '0);

    // Load every register from port i%8 and commit in the same cycle.
    set_ports(16'h1000);
    bus.reg_load    = '1;
    bus.fill_commit = 1'b1;
    tick();
    cmp("c0_mac_valid", 64'(bus.mac_valid), 64'd1);
    cmp("c0_full_cnt", 64'(bus.full_cnt), 64'd1);
    cmp("c0_fill_ready", 64'(bus.fill_ready), 64'd1);
    cmp_lanes("c0_lanes", pat_mod(16'h1000));

    set_ports(16'h2000);
    bus.reg_load    = '1;
    bus.fill_commit = 1'b1;
    tick();
    cmp("c1_full_cnt", 64'(bus.full_cnt), 64'd2);
    cmp("c1_fill_ready", 64'(bus.fill_ready), 64'd0);

    set_ports(16'h7777);
    bus.reg_load[5] = 1'b1;
    tick();
    cmp("full_load_err", 64'(bus.err), 64'd1);
    cmp_lanes("full_load_lanes", pat_mod(16'h1000));

    bus.err_clr = 1'b1;
    tick();
    cmp("err_clr", 64'(bus.err), 64'd0);

    bus.mac_release = 1'b1;
    tick();
    cmp("rel0_full_cnt", 64'(bus.full_cnt), 64'd1);
    cmp_lanes("rel0_lanes", pat_mod(16'h2000));

    // Fill lane i = i, shift alone, then commit+release together.
    load_identity();
    bus.shift_en = 1'b1;
    tick();
    bus.fill_commit = 1'b1;
    bus.mac_release = 1'b1;
    tick();
    cmp("swap_full_cnt", 64'(bus.full_cnt), 64'd1);
    cmp("swap_mac_valid", 64'(bus.mac_valid), 64'd1);
    cmp("swap_fill_ready", 64'(bus.fill_ready), 64'd1);
    cmp_lanes("shift_lanes", pat_shifted());

    bus.mac_release = 1'b1;
    tick();
    cmp("rel1_mac_valid", 64'(bus.mac_valid), 64'd0);

    // Shift, load, clear and commit in one cycle.
    load_identity();
    bus.rd_data[3*DW +: DW] = 16'hBEEF;
    bus.mux_sel[0 +: SW]    = 3'd3;
    bus.reg_load            = 64'h1;
    bus.local_clr           = 64'h4;
    bus.shift_en            = 1'b1;
    bus.fill_commit         = 1'b1;
    tick();
    exp_v = pat_shifted();
    exp_v[0 +: DW]    = 16'hBEEF;
    exp_v[2*DW +: DW] = '0;
    cmp("ls_lane0", 64'(bus.mac_in[0 +: DW]), 64'hBEEF);
    cmp("ls_lane1", 64'(bus.mac_in[DW +: DW]), 64'd9);
    cmp("ls_lane2", 64'(bus.mac_in[2*DW +: DW]), 64'd0);
    cmp_lanes("ls_lanes", exp_v);

    // Mid-fill asynchronous reset, between clock edges.
    set_ports(16'h3000);
    bus.reg_load = '1;
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    cmp("arst_fill_ready", 64'(bus.fill_ready), 64'd1);
    cmp("arst_mac_valid", 64'(bus.mac_valid), 64'd0);
    cmp("arst_full_cnt", 64'(bus.full_cnt), 64'd0);
    cmp_lanes("arst_mac_in", '0);
    #1;
    rst_n = 1'b1;

    bus.mac_release = 1'b1;
    tick();
    cmp("rel_empty_err", 64'(bus.err), 64'd1);

    bus.mac_release = 1'b1;
    bus.err_clr     = 1'b1;
    tick();
    cmp("err_set_wins", 64'(bus.err), 64'd1);

    bus.err_clr = 1'b1;
    tick();
    cmp("err_clr2", 64'(bus.err), 64'd0);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/if_map_buf_pp.md
Name: if_map_buf_pp

Overview:
- Parametrised, double-buffered (ping-pong) input-feature-map register buffer feeding the MAC array's first operand bus.
- The fill bank is loaded per register from one of NUM_PORTS memory read ports, or shifted by a fixed step for strided window reuse.
- The compute bank is presented to the MACs under a commit/release handshake, so the next window fills while the current one is consumed.

Parameters:
DATA_W, 16, width of one feature-map element
NUM_REGS, 64, registers per bank (= MAC lanes)
NUM_PORTS, 8, number of read-data ports
SEL_W, $clog2(NUM_PORTS), per-register mux select width
SHIFT_STEP, 8, register-index distance moved by one shift (one window row)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
rd_data  in  NUM_PORTS*DATA_W  read ports; port p = [p*DATA_W +: DATA_W]
reg_load  in  NUM_REGS  per-register load enable (fill bank)
mux_sel  in  NUM_REGS*SEL_W  per-register port select; reg i = [i*SEL_W +: SEL_W]
local_clr  in  NUM_REGS  per-register synchronous clear (fill bank)
shift_en  in  1  shift fill bank down by SHIFT_STEP
fill_commit  in  1  fill bank complete; hand to MAC side
fill_ready  out  1  fill bank writable
mac_release  in  1  MAC side finished with compute bank
mac_valid  out  1  compute bank holds committed data
mac_in  out  NUM_REGS*DATA_W  compute-bank contents; reg i = [i*DATA_W +: DATA_W]
full_cnt  out  2  number of committed banks (0..2)
err  out  1  sticky protocol-violation flag
err_clr  in  1  clears err

Behaviour:
- State: bank[0..1][NUM_REGS], pointers wr_bank and rd_bank, flags full[0..1].
- Reset (reset=0, async): all bank registers 0, wr_bank=rd_bank=0, full=00, err=0; outputs: fill_ready=1, mac_valid=0, full_cnt=0, mac_in=0.
- Combinational outputs:
  - fill_ready = !full[wr_bank]
  - mac_valid = full[rd_bank]
  - full_cnt = full[0]+full[1]
  - mac_in = bank[rd_bank] when mac_valid, else all zeros
- Fill-bank write, only when fill_ready=1; per register i, priority highest first:
  1. local_clr[i]: reg <= 0.
  2. reg_load[i]: reg <= port mux_sel[i]; a select >= NUM_PORTS loads 0.
  3. shift_en: reg[i] <= reg[i+SHIFT_STEP] for i < NUM_REGS-SHIFT_STEP; top SHIFT_STEP regs <= 0.
  4. Otherwise hold.
- Load and shift in the same cycle: loaded registers take port data, all others shift. The shift source is always the pre-edge value.
- Commit: fill_commit & fill_ready -> full[wr_bank]<=1, wr_bank<=~wr_bank. Any load, clear or shift in the same cycle still lands in the committing bank.
- Release: mac_release & mac_valid -> full[rd_bank]<=0, rd_bank<=~rd_bank. The released bank's contents are retained, not cleared.
- Commit and release in the same cycle both take effect; they always address different banks.
- Latency:
  - Load to committed: 1 cycle.
  - Commit edge to mac_valid=1: the same edge (flag registered, output combinational from flags). mac_in is stable from that edge.
- Both banks full: fill_ready=0; reg_load, local_clr, shift_en and fill_commit are ignored and the bank is unchanged.
- Errors: err<=1 on (fill_commit | shift_en | |reg_load | |local_clr) & !fill_ready, or mac_release & !mac_valid. err_clr clears it; a set condition in the same cycle wins.
- Reset mid-operation discards all data and flags immediately; no partial swap survives.

Test Plan:
- After reset: fill_ready=1, mac_valid=0, mac_in=0, full_cnt=0.
- Load all 64 regs, reg i selecting port i%8 (port p = 0x1000+p), then commit:
  - Next cycle mac_valid=1, full_cnt=1, fill_ready=1.
  - mac_in lane i = 0x1000+(i%8).
- Fill and commit bank 1 without releasing:
  - full_cnt=2, fill_ready=0.
  - A further reg_load is ignored and sets err=1; mac_in still shows bank 0.
- With lane i = i, pulse shift_en alone: lane i = i+8 for i<56, lanes 56..63 = 0. Same cycle with reg_load[0]=1 from port 3 (0xBEEF): lane0 = 0xBEEF, lane1 = 9.
- Same-cycle commit and release with bank 0 full and bank 1 filling: rd_bank and wr_bank both toggle, full_cnt stays 1, mac_in switches to bank 1 contents.
- Pull reset low mid-fill, asynchronous to clk: all outputs return to reset values before the next clock edge; mac_release with mac_valid=0 afterwards sets err.
